// File: rtl/bus_master_ctrl.sv
// Master-side burst sequencer: requests the bus, issues one beat per granted cycle with an
// incrementing address, then releases the request (held one extra cycle after a read burst).
module bus_master_ctrl #(
   parameter int unsigned AddrW = 8,
   parameter int unsigned DataW = 32,
   parameter int unsigned LenW  = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_wr_i,
   input  logic [AddrW-1:0] cmd_addr_i,
   input  logic [LenW-1:0]  cmd_len_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic             wdata_valid_i,
   output logic             wdata_ready_o,
   output logic [DataW-1:0] rdata_o,
   output logic             rdata_valid_o,
   output logic             busy_o,
   output logic             m_request_o,
   input  logic             m_grant_i,
   output logic             m_en_o,
   output logic             m_wr_o,
   output logic [AddrW-1:0] m_addr_o,
   output logic [DataW-1:0] m_dout_o,
   input  logic [DataW-1:0] m_din_i
);

   typedef enum logic [1:0] {StIdle, StReq, StXfer, StRtail} state_e;

   state_e             state_q, state_d;
   logic               req_q, req_d;
   logic               wr_q, wr_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [LenW-1:0]    len_q, len_d;
   logic [LenW-1:0]    cnt_q, cnt_d;
   logic               rd_pend_q;
   logic [DataW-1:0]   rdata_q;
   logic               rdata_valid_q;
   logic               beat;

   // A write beat needs data in hand; a read beat only needs the grant.
   assign beat = (state_q == StXfer) && m_grant_i && (!wr_q || wdata_valid_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         req_q         <= 1'b0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         rd_pend_q     <= 1'b0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         wr_q          <= wr_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         // Slave data for a read beat is on m_din the cycle after the beat.
         rd_pend_q     <= beat && !wr_q;
         rdata_valid_q <= rd_pend_q;
         if (rd_pend_q) begin
            rdata_q <= m_din_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               wr_d    = cmd_wr_i;
               addr_d  = cmd_addr_i;
               len_d   = cmd_len_i;
               cnt_d   = '0;
               req_d   = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            if (m_grant_i) begin
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (beat) begin
               addr_d = addr_q + AddrW'(1);
               cnt_d  = cnt_q + LenW'(1);
               if (cnt_q == len_q) begin
                  if (wr_q) begin
                     req_d   = 1'b0;
                     state_d = StIdle;
                  end else begin
                     state_d = StRtail;
                  end
               end
            end
         end
         StRtail: begin
            req_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready_o   = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign m_request_o   = req_q;
   assign m_en_o        = beat;
   assign m_wr_o        = beat && wr_q;
   assign m_addr_o      = addr_q;
   assign m_dout_o      = wdata_i;
   assign wdata_ready_o = beat && wr_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: scoreboard of expected beats and read returns, plus a
// second instance sharing a small bench-side arbiter for the contention case.
module tb_bus_master_ctrl;

   typedef struct {
      logic [7:0]  addr;
      logic        wr;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   int          cyc = 0;

   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [7:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic [31:0] wdata;
   logic        wdata_valid, wdata_ready;
   logic [31:0] rdata;
   logic        rdata_valid, busy;
   logic        m_request, m_en, m_wr;
   logic [7:0]  m_addr;
   logic [31:0] m_dout;
   logic [31:0] m_din = 32'h0;
   logic        g0, tb_g0;

   logic        s1_valid, s1_ready, s1_wr;
   logic [7:0]  s1_addr;
   logic [3:0]  s1_len;
   logic [31:0] s1_rdata, s1_dout;
   logic        s1_wready, s1_rvalid, s1_busy, s1_request, s1_en, s1_mwr;
   logic [7:0]  s1_maddr;
   logic        g1;

   logic        arb_mode;
   logic [1:0]  owner_q;

   beat_t       beat_q[$];
   rd_t         rd_q[$];
   logic [31:0] din_next = 32'hDEAD_BEEF;
   logic        in_flight;
   int          n_cmp, n_err;
   int          tnum, wd_idx, acc_cyc, first_cyc, last_cyc;
   int          n_beats1, first1, overlaps;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) m_din <= din_next;

   // Owner holds the grant until it drops its request; M0 wins ties.
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) owner_q <= 2'd0;
      else begin
         case (owner_q)
            2'd0: owner_q <= m_request ? 2'd1 : (s1_request ? 2'd2 : 2'd0);
            2'd1: if (!m_request) owner_q <= s1_request ? 2'd2 : 2'd0;
            2'd2: if (!s1_request) owner_q <= m_request ? 2'd1 : 2'd0;
            default: owner_q <= 2'd0;
         endcase
      end
   end

   assign g0 = arb_mode ? (owner_q == 2'd1) : tb_g0;
   assign g1 = arb_mode && (owner_q == 2'd2);

   bus_master_ctrl u_dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .wdata_i(wdata),
      .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .rdata_o(rdata),
      .rdata_valid_o(rdata_valid), .busy_o(busy), .m_request_o(m_request), .m_grant_i(g0),
      .m_en_o(m_en), .m_wr_o(m_wr), .m_addr_o(m_addr), .m_dout_o(m_dout), .m_din_i(m_din)
   );

   bus_master_ctrl u_dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(s1_valid), .cmd_ready_o(s1_ready),
      .cmd_wr_i(s1_wr), .cmd_addr_i(s1_addr), .cmd_len_i(s1_len), .wdata_i(32'h1111_0000),
      .wdata_valid_i(1'b1), .wdata_ready_o(s1_wready), .rdata_o(s1_rdata),
      .rdata_valid_o(s1_rvalid), .busy_o(s1_busy), .m_request_o(s1_request), .m_grant_i(g1),
      .m_en_o(s1_en), .m_wr_o(s1_mwr), .m_addr_o(s1_maddr), .m_dout_o(s1_dout),
      .m_din_i(m_din)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wd_val(input int idx);
      return 32'hC0DE_0000 + 32'(tnum << 8) + 32'(idx);
   endfunction

   task automatic monitor();
      beat_t b;
      rd_t   r;
      din_next = 32'hDEAD_BEEF;
      if (m_en) begin
         if (beat_q.size() == 0) chk("unexpected_beat", 32'(m_addr), 32'hFFFF_FFFF);
         else begin
            b = beat_q.pop_front();
            chk("beat_addr", 32'(m_addr), 32'(b.addr));
            chk("beat_wr", 32'(m_wr), 32'(b.wr));
            if (b.wr) chk("beat_data", m_dout, b.data);
            else begin
               din_next = 32'h100 + 32'(m_addr);
               r.data = din_next;
               r.cyc  = cyc + 2;
               rd_q.push_back(r);
            end
         end
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end else if (in_flight && beat_q.size() != 0) begin
         chk("hold_addr", 32'(m_addr), 32'(beat_q[0].addr));
      end
      if (in_flight) chk("request_held", 32'(m_request), 32'd1);
      if (rdata_valid) begin
         if (rd_q.size() == 0) chk("unexpected_rdata", rdata, 32'hFFFF_FFFF);
         else begin
            r = rd_q.pop_front();
            chk("rdata", rdata, r.data);
            chk("rdata_cycle", 32'(cyc), 32'(r.cyc));
         end
      end
      if (m_en && s1_en) overlaps++;
      if (s1_en) begin
         n_beats1++;
         if (n_beats1 == 1) first1 = cyc;
      end
   endtask

   task automatic step();
      logic took;
      @(negedge clk);
      monitor();
      took = wdata_ready;
      @(posedge clk);
      #1;
      if (took) begin
         wd_idx++;
         wdata = wd_val(wd_idx);
      end
   endtask

   task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                          input logic [63:0] gpat, input logic [63:0] vpat, input int stop_k);
      beat_t b;
      int    k;
      int    limit;
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      wd_idx    = 0;
      wdata     = wd_val(0);
      for (int i = 0; i <= int'(len); i++) begin
         b.addr = addr + 8'(i);
         b.wr   = wr;
         b.data = wd_val(i);
         beat_q.push_back(b);
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      acc_cyc   = cyc;
      first_cyc = -1;
      step();
      cmd_valid = 1'b0;
      s1_valid  = 1'b0;
      in_flight = 1'b1;
      limit     = (stop_k != 0) ? stop_k : 60;
      k         = 0;
      while (beat_q.size() > 0 && k < limit) begin
         tb_g0       = gpat[k];
         wdata_valid = vpat[k];
         step();
         k++;
      end
      if (stop_k == 0) chk("burst_done", 32'(beat_q.size()), 32'd0);
      in_flight = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && rd_q.size() > 0; i++) step();
      chk("rdata_drained", 32'(rd_q.size()), 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; tnum = 0; in_flight = 1'b0; arb_mode = 1'b0;
      overlaps = 0; n_beats1 = 0; first1 = 0; first_cyc = -1; last_cyc = 0;
      rst_ni = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h0; cmd_len = 4'h0;
      wdata = 32'h0; wdata_valid = 1'b0; tb_g0 = 1'b0;
      s1_valid = 1'b0; s1_wr = 1'b0; s1_addr = 8'h0; s1_len = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_request", 32'(m_request), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rvalid", 32'(rdata_valid), 32'd0);
      step();

      // 1: write burst, grant arrives two cycles after the request
      tnum = 1;
      run_cmd(1'b1, 8'h10, 4'd3, ~64'h3, ~64'h0, 0);
      chk("t1_first_beat_lat", 32'(first_cyc - acc_cyc), 32'd4);
      chk("t1_beat_span", 32'(last_cyc - first_cyc), 32'd3);
      chk("t1_request_fall", 32'(m_request), 32'd0);
      chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
      tb_g0 = 1'b0;
      step();

      // 2: read burst wrapping the address space
      tnum = 2;
      run_cmd(1'b0, 8'hFE, 4'd2, ~64'h0, ~64'h0, 0);
      chk("t2_beat_span", 32'(last_cyc - first_cyc), 32'd2);
      chk("t2_rtail_request", 32'(m_request), 32'd1);
      chk("t2_rtail_busy", 32'(busy), 32'd1);
      chk("t2_rtail_m_en", 32'(m_en), 32'd0);
      step();
      chk("t2_request_fall", 32'(m_request), 32'd0);
      chk("t2_cmd_ready", 32'(cmd_ready), 32'd1);
      drain();
      tb_g0 = 1'b0;

      // 3: write with a three-cycle data stall before beat 2
      tnum = 3;
      run_cmd(1'b1, 8'h40, 4'd3, ~64'h0, ~(64'h7 << 3), 0);
      chk("t3_first_beat_lat", 32'(first_cyc - acc_cyc), 32'd2);
      chk("t3_beat_span", 32'(last_cyc - first_cyc), 32'd6);
      chk("t3_request_fall", 32'(m_request), 32'd0);
      tb_g0 = 1'b0; wdata_valid = 1'b0;
      step();

      // 4: read burst with grant withdrawn for two cycles after beat 3
      tnum = 4;
      run_cmd(1'b0, 8'h80, 4'd7, ~(64'h3 << 5), ~64'h0, 0);
      chk("t4_beat_span", 32'(last_cyc - first_cyc), 32'd9);
      step();
      drain();
      tb_g0 = 1'b0;

      // 5: asynchronous reset in the middle of a read burst
      tnum = 5;
      run_cmd(1'b0, 8'h20, 4'd7, ~64'h0, ~64'h0, 3);
      chk("t5_pre_rvalid", 32'(rdata_valid), 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t5_async_request", 32'(m_request), 32'd0);
      chk("t5_async_m_en", 32'(m_en), 32'd0);
      chk("t5_async_rvalid", 32'(rdata_valid), 32'd0);
      beat_q.delete();
      rd_q.delete();
      step();
      step();
      rst_ni = 1'b1;
      chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      repeat (4) step();
      tb_g0 = 1'b0;

      // 6: both instances contend through the arbiter
      tnum = 6;
      arb_mode = 1'b1; n_beats1 = 0; overlaps = 0;
      s1_valid = 1'b1; s1_wr = 1'b1; s1_addr = 8'h60; s1_len = 4'd3;
      run_cmd(1'b1, 8'h50, 4'd3, ~64'h0, ~64'h0, 0);
      for (int i = 0; i < 40 && n_beats1 < 4; i++) step();
      chk("t6_m1_beats", 32'(n_beats1), 32'd4);
      chk("t6_m1_after_m0", 32'(first1 > last_cyc), 32'd1);
      chk("t6_overlap", 32'(overlaps), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
